// File: rtl/sha256_msg_ctrl_pkg.sv
// Shared constants, FSM state type and helpers for the SHA-256 message controller
// and its block padder.
package sha_pkg;
    localparam int         BLK_BITS  = 512;
    localparam int         BLK_BYTES = BLK_BITS / 8;
    localparam int         DIG_BITS  = 256;
    localparam int         CNT_BITS  = 32;
    localparam int         LEN_OFFS  = 56;
    localparam logic [7:0] PAD_BYTE  = 8'h80;

    typedef enum logic [1:0] {ST_DATA, ST_PAD, ST_WAIT, ST_OUT} state_t;

    // PM_LAST: tail beat with n bytes; PM_PAD: extra length-only block.
    typedef enum logic [1:0] {PM_PASS, PM_LAST, PM_PAD} pad_mode_t;

    function automatic logic [6:0] popcount64(input logic [63:0] keep);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++) n = n + 7'(keep[i]);
        return n;
    endfunction
endpackage

// File: rtl/sha256_msg_ctrl_if.sv
// Stream, block and digest signals of the SHA-256 message controller.
// Every valid/ready pair: a transfer happens on a rising clock edge where both are
// high; the source keeps valid and its payload unchanged until that transfer.
interface sha256_msg_ctrl_if;
    import sha_pkg::*;

    logic [BLK_BITS-1:0]  s_tdata;
    logic [BLK_BYTES-1:0] s_tkeep;
    logic                 s_tlast;
    logic                 s_tvalid;
    logic                 s_tready;

    logic [BLK_BITS-1:0]  blk_data;
    logic                 blk_first;
    logic                 blk_last;
    logic                 blk_valid;
    logic                 blk_ready;

    logic [DIG_BITS-1:0]  dig_data;
    logic                 dig_valid;

    logic [BLK_BITS-1:0]  m_tdata;
    logic [BLK_BYTES-1:0] m_tkeep;
    logic                 m_tlast;
    logic                 m_tvalid;
    logic                 m_tready;

    modport slave (
        input  s_tdata, s_tkeep, s_tlast, s_tvalid,
        output s_tready,
        output blk_data, blk_first, blk_last, blk_valid,
        input  blk_ready,
        input  dig_data, dig_valid,
        output m_tdata, m_tkeep, m_tlast, m_tvalid,
        input  m_tready
    );

    modport master (
        output s_tdata, s_tkeep, s_tlast, s_tvalid,
        input  s_tready,
        input  blk_data, blk_first, blk_last, blk_valid,
        output blk_ready,
        output dig_data, dig_valid,
        input  m_tdata, m_tkeep, m_tlast, m_tvalid,
        output m_tready
    );
endinterface

// File: rtl/sha256_msg_ctrl_pad_blk.sv
// Combinational SHA-256 block former: pass-through, tail-beat padding, or the
// extra length-only block. Length is the big-endian bit count in bytes 56..63.
module sha256_pad_blk
    import sha_pkg::*;
(
    input  logic [BLK_BITS-1:0] data,
    input  logic [6:0]          n,
    input  logic [60:0]         count,
    input  pad_mode_t           mode,
    output logic [BLK_BITS-1:0] blk
);
    logic [63:0] len_bits;
    logic        put_len;

    assign len_bits = {count, 3'b000};
    assign put_len  = (mode == PM_PAD) || ((mode == PM_LAST) && (n <= 7'd55));

    always_comb begin
        blk = '0;
        for (int i = 0; i < BLK_BYTES; i++) begin
            if ((mode == PM_PASS) || ((mode == PM_LAST) && (7'(i) < n)))
                blk[8*i +: 8] = data[8*i +: 8];
            else if ((mode == PM_LAST) && (7'(i) == n))
                blk[8*i +: 8] = PAD_BYTE;
        end
        // A full 64-byte tail left no room for the marker, so it opens the extra block.
        if ((mode == PM_PAD) && (n == 7'd64))
            blk[7:0] = PAD_BYTE;
        if (put_len) begin
            for (int j = 0; j < 8; j++)
                blk[8*(LEN_OFFS+j) +: 8] = len_bits[8*(7-j) +: 8];
        end
    end
endmodule

// File: rtl/sha256_msg_ctrl.sv
// Message-level SHA-256 controller: pads a byte stream into 512-bit blocks for the
// compression core, then returns the digest as a single-beat stream packet.
module sha256_msg_ctrl
    import sha_pkg::*;
(
    input  logic                aclk,
    input  logic                aresetn,
    sha256_msg_ctrl_if.slave    bus,
    output logic [CNT_BITS-1:0] msg_cnt,
    output logic                err,
    output state_t              dbg_state
);
    state_t              state, state_nxt;
    logic [60:0]         byte_cnt, cnt_sum;
    logic                first_flag, pad_full, dig_got;
    logic [DIG_BITS-1:0] dig_reg;
    logic [BLK_BITS-1:0] blk_data_q;
    logic                blk_first_q, blk_last_q, blk_valid_q, m_valid_q;
    logic [6:0]          n_keep;
    logic                blk_free, s_accept;
    logic                pad_load, dig_take, to_out, out_done;
    pad_mode_t           pad_mode;
    logic [6:0]          pad_n;
    logic [60:0]         pad_count;
    logic [BLK_BITS-1:0] pad_out;

    assign n_keep   = popcount64(bus.s_tkeep);
    assign cnt_sum  = byte_cnt + 61'(n_keep);
    assign blk_free = !blk_valid_q || bus.blk_ready;
    assign s_accept = bus.s_tvalid && bus.s_tready;

    assign bus.s_tready  = (state == ST_DATA) && blk_free;
    assign bus.blk_data  = blk_data_q;
    assign bus.blk_first = blk_first_q;
    assign bus.blk_last  = blk_last_q;
    assign bus.blk_valid = blk_valid_q;
    assign bus.m_tdata   = {{(BLK_BITS-DIG_BITS){1'b0}}, dig_reg};
    assign bus.m_tkeep   = m_valid_q ? {32'h0000_0000, 32'hFFFF_FFFF} : '0;
    assign bus.m_tlast   = m_valid_q;
    assign bus.m_tvalid  = m_valid_q;
    assign dbg_state     = state;

    // The padder either shapes the incoming beat or, in ST_PAD, builds the extra block.
    always_comb begin
        if (state == ST_PAD) begin
            pad_mode  = PM_PAD;
            pad_n     = pad_full ? 7'd64 : 7'd0;
            pad_count = byte_cnt;
        end else begin
            pad_mode  = bus.s_tlast ? PM_LAST : PM_PASS;
            pad_n     = n_keep;
            pad_count = cnt_sum;
        end
    end

    sha256_pad_blk u_pad (
        .data  (bus.s_tdata),
        .n     (pad_n),
        .count (pad_count),
        .mode  (pad_mode),
        .blk   (pad_out)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= ST_DATA;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pad_load  = 1'b0;
        dig_take  = 1'b0;
        to_out    = 1'b0;
        out_done  = 1'b0;
        case (state)
            ST_DATA: begin
                if (s_accept && bus.s_tlast)
                    state_nxt = (n_keep <= 7'd55) ? ST_WAIT : ST_PAD;
            end
            ST_PAD: begin
                if (blk_free) begin
                    pad_load  = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // The digest may arrive in the very cycle the final block is taken.
                dig_take = bus.dig_valid;
                if (blk_free && (bus.dig_valid || dig_got)) begin
                    to_out    = 1'b1;
                    state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                if (bus.m_tready) begin
                    out_done  = 1'b1;
                    state_nxt = ST_DATA;
                end
            end
            default: state_nxt = ST_DATA;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            blk_data_q  <= '0;
            blk_first_q <= 1'b0;
            blk_last_q  <= 1'b0;
            blk_valid_q <= 1'b0;
            byte_cnt    <= '0;
            first_flag  <= 1'b1;
            pad_full    <= 1'b0;
            dig_got     <= 1'b0;
            dig_reg     <= '0;
            m_valid_q   <= 1'b0;
            msg_cnt     <= '0;
            err         <= 1'b0;
        end else begin
            if (blk_valid_q && bus.blk_ready)
                blk_valid_q <= 1'b0;
            if (s_accept || pad_load) begin
                blk_valid_q <= 1'b1;
                blk_data_q  <= pad_out;
                blk_first_q <= s_accept && first_flag;
                blk_last_q  <= pad_load || (bus.s_tlast && (n_keep <= 7'd55));
            end
            if (s_accept) begin
                byte_cnt   <= cnt_sum;
                first_flag <= 1'b0;
                pad_full   <= (n_keep == 7'd64);
            end
            if (dig_take) begin
                dig_reg <= bus.dig_data;
                dig_got <= 1'b1;
            end
            if (to_out)
                m_valid_q <= 1'b1;
            if (out_done) begin
                m_valid_q  <= 1'b0;
                msg_cnt    <= msg_cnt + CNT_BITS'(1);
                byte_cnt   <= '0;
                first_flag <= 1'b1;
                dig_got    <= 1'b0;
            end
            if (bus.dig_valid && (state != ST_WAIT))
                err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Bench for sha256_msg_ctrl: padding vector table, randomized messages against a
// byte-string padding model, and hand sequences for stalls, mid-message reset and err.
module tb_sha256_msg_ctrl;
    import sha_pkg::*;

    logic                aclk;
    logic                aresetn;
    logic [CNT_BITS-1:0] msg_cnt;
    logic                err;
    state_t              dbg_state;

    sha256_msg_ctrl_if bus();

    sha256_msg_ctrl dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .bus       (bus),
        .msg_cnt   (msg_cnt),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int           total = 0;
    int           bad   = 0;
    logic [513:0] exp_q[$];       // {first, last, block}
    logic [255:0] dig_src_q[$];   // digests the core model will return
    logic [255:0] exp_dig_q[$];   // digests expected on the output stream
    int           blk_cnt   = 0;
    logic [511:0] last_blk  = '0;
    int           rdy_mode  = 0;  // 0: random blk_ready, 1: blk_ready held low
    int           m_mode    = 0;  // 0: random m_tready, 1: m_tready held low
    int           stray_cnt = 0;

    typedef struct {
        int          len;
        int          nblk;
        logic [15:0] tail;
    } vec_t;
    vec_t vecs[9];

    localparam logic [255:0] ABC_DIG =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

    task automatic chk(input string name, input logic [513:0] got, input logic [513:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // ---------------- compression core model ----------------
    initial begin : core_model
        logic [513:0] cur;
        logic [513:0] prev;
        logic [255:0] pend_dig;
        bit           prev_stall;
        int           dig_cd;
        int           stray_done;
        prev = '0;
        pend_dig = '0;
        prev_stall = 0;
        dig_cd = 0;
        stray_done = 0;
        bus.blk_ready = 1'b0;
        bus.dig_valid = 1'b0;
        bus.dig_data  = '0;
        forever begin
            @(negedge aclk);
            bus.dig_valid = 1'b0;
            if (!aresetn) begin
                prev_stall = 0;
                dig_cd = 0;
                bus.blk_ready = 1'b0;
                continue;
            end
            if (dig_cd > 0) begin
                dig_cd--;
                if (dig_cd == 0) begin
                    bus.dig_valid = 1'b1;
                    bus.dig_data  = pend_dig;
                end
            end
            if (stray_done != stray_cnt) begin
                stray_done    = stray_cnt;
                bus.dig_valid = 1'b1;
                bus.dig_data  = {8{32'hdead_beef}};
            end
            bus.blk_ready = (rdy_mode == 0) ? ($urandom_range(0, 3) != 0) : 1'b0;
            cur = {bus.blk_first, bus.blk_last, bus.blk_data};
            if (prev_stall) begin
                chk("blk_hold_valid", 514'(bus.blk_valid), 514'(1));
                chk("blk_hold_data", cur, prev);
            end
            prev_stall = bus.blk_valid && !bus.blk_ready;
            prev = cur;
            if (bus.blk_valid && bus.blk_ready) begin
                blk_cnt++;
                last_blk = bus.blk_data;
                if (exp_q.size() == 0) fail_now("blk_extra");
                else chk("blk", cur, exp_q.pop_front());
                if (bus.blk_last) begin
                    if (dig_src_q.size() == 0) begin
                        fail_now("dig_src_empty");
                    end else begin
                        pend_dig = dig_src_q.pop_front();
                        dig_cd = $urandom_range(0, 3);
                        if (dig_cd == 0) begin
                            bus.dig_valid = 1'b1;
                            bus.dig_data  = pend_dig;
                        end
                    end
                end
            end
        end
    end

    // ---------------- output stream monitor ----------------
    initial begin : out_monitor
        logic [511:0] prev_d;
        logic [255:0] e;
        bit           prev_stall;
        prev_d = '0;
        prev_stall = 0;
        bus.m_tready = 1'b0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                prev_stall = 0;
                bus.m_tready = 1'b0;
                continue;
            end
            bus.m_tready = (m_mode == 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
            if (prev_stall) begin
                chk("m_hold_valid", 514'(bus.m_tvalid), 514'(1));
                chk("m_hold_data", 514'(bus.m_tdata), 514'(prev_d));
            end
            prev_stall = bus.m_tvalid && !bus.m_tready;
            prev_d = bus.m_tdata;
            if (bus.m_tvalid && bus.m_tready) begin
                if (exp_dig_q.size() == 0) begin
                    fail_now("m_extra");
                end else begin
                    e = exp_dig_q.pop_front();
                    chk("m_tdata", 514'(bus.m_tdata), 514'(e));
                    chk("m_tkeep", 514'(bus.m_tkeep), 514'(64'h0000_0000_FFFF_FFFF));
                    chk("m_tlast", 514'(bus.m_tlast), 514'(1));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_bytes(input logic [7:0] msg[$], input logic [255:0] dig);
        logic [7:0]   padded[$];
        logic [63:0]  bits;
        logic [511:0] blk;
        int           nb_exp;
        int           nbeats;
        int           guard;
        // Reference padding on the whole message as a byte string.
        padded = msg;
        bits = 64'(msg.size()) << 3;
        padded.push_back(8'h80);
        while (padded.size() % 64 != 56) padded.push_back(8'h00);
        for (int j = 7; j >= 0; j--) padded.push_back(bits[8*j +: 8]);
        nb_exp = padded.size() / 64;
        for (int b = 0; b < nb_exp; b++) begin
            for (int i = 0; i < 64; i++) blk[8*i +: 8] = padded[64*b + i];
            exp_q.push_back({b == 0, b == nb_exp - 1, blk});
        end
        dig_src_q.push_back(dig);
        exp_dig_q.push_back(dig);

        nbeats = (msg.size() == 0) ? 1 : (msg.size() + 63) / 64;
        for (int b = 0; b < nbeats; b++) begin
            @(negedge aclk);
            for (int i = 0; i < 64; i++) begin
                if (64*b + i < msg.size()) begin
                    bus.s_tdata[8*i +: 8] = msg[64*b + i];
                    bus.s_tkeep[i] = 1'b1;
                end else begin
                    bus.s_tdata[8*i +: 8] = 8'($urandom_range(0, 255));
                    bus.s_tkeep[i] = 1'b0;
                end
            end
            bus.s_tlast  = (b == nbeats - 1);
            bus.s_tvalid = 1'b1;
            #1;
            guard = 0;
            while (!bus.s_tready && guard < 2000) begin
                @(negedge aclk);
                #1;
                guard++;
            end
            if (!bus.s_tready) fail_now($sformatf("s_tready_timeout beat=%0d", b));
            @(posedge aclk);
        end
        @(negedge aclk);
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
    endtask

    task automatic rand_msg(input int len);
        logic [7:0]   m[$];
        logic [255:0] d;
        for (int i = 0; i < len; i++) m.push_back(8'($urandom_range(0, 255)));
        for (int k = 0; k < 8; k++) d[32*k +: 32] = $urandom();
        send_bytes(m, d);
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || exp_dig_q.size() != 0) && guard < 5000) begin
            @(negedge aclk);
            #2;
            guard++;
        end
        if (guard >= 5000) fail_now("done_timeout");
        @(negedge aclk);
        #2;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main_seq
        int           c0;
        int           msgs;
        int           guard;
        logic [7:0]   abc[$];

        vecs = '{'{0,   1, 16'h0000}, '{3,   1, 16'h0018}, '{55,  1, 16'h01B8},
                 '{56,  2, 16'h01C0}, '{63,  2, 16'h01F8}, '{64,  2, 16'h0200},
                 '{119, 2, 16'h03B8}, '{120, 3, 16'h03C0}, '{128, 3, 16'h0400}};
        msgs = 0;
        aresetn      = 1'b0;
        bus.s_tdata  = '0;
        bus.s_tkeep  = '0;
        bus.s_tlast  = 1'b0;
        bus.s_tvalid = 1'b0;
        repeat (3) @(negedge aclk);
        chk("rst_blk_valid", 514'(bus.blk_valid), 514'(0));
        chk("rst_blk_data", 514'(bus.blk_data), 514'(0));
        chk("rst_m_tvalid", 514'(bus.m_tvalid), 514'(0));
        chk("rst_m_tkeep", 514'(bus.m_tkeep), 514'(0));
        chk("rst_msg_cnt", 514'(msg_cnt), 514'(0));
        chk("rst_err", 514'(err), 514'(0));
        chk("rst_state", 514'(dbg_state), 514'(ST_DATA));
        #2 aresetn = 1'b1;

        // Padding boundary table with random data and random back-pressure.
        for (int v = 0; v < 9; v++) begin
            c0 = blk_cnt;
            rand_msg(vecs[v].len);
            wait_done();
            msgs++;
            chk($sformatf("nblk_len%0d", vecs[v].len), 514'(blk_cnt - c0), 514'(vecs[v].nblk));
            chk($sformatf("tail_len%0d", vecs[v].len),
                514'({last_blk[8*62 +: 8], last_blk[8*63 +: 8]}), 514'(vecs[v].tail));
        end

        for (int r = 0; r < 20; r++) begin
            rand_msg($urandom_range(0, 200));
            wait_done();
            msgs++;
        end
        chk("msg_cnt_total", 514'(msg_cnt), 514'(msgs));
        chk("err_clean", 514'(err), 514'(0));

        // Reset while a 60-byte message sits in ST_PAD with the core stalled.
        rdy_mode = 1;
        rand_msg(60);
        repeat (2) @(negedge aclk);
        #1;
        chk("pad_state", 514'(dbg_state), 514'(ST_PAD));
        chk("pad_s_tready", 514'(bus.s_tready), 514'(0));
        chk("pad_blk_valid", 514'(bus.blk_valid), 514'(1));
        #2 aresetn = 1'b0;
        #1;
        chk("arst_blk_valid", 514'(bus.blk_valid), 514'(0));
        chk("arst_blk_data", 514'({bus.blk_first, bus.blk_last, bus.blk_data}), 514'(0));
        chk("arst_msg_cnt", 514'(msg_cnt), 514'(0));
        chk("arst_state", 514'(dbg_state), 514'(ST_DATA));
        exp_q.delete();
        dig_src_q.delete();
        exp_dig_q.delete();
        @(negedge aclk);
        #2 aresetn = 1'b1;
        rdy_mode = 0;

        // "abc" with the output held off for ten cycles.
        m_mode = 1;
        abc = '{8'h61, 8'h62, 8'h63};
        c0 = blk_cnt;
        send_bytes(abc, ABC_DIG);
        guard = 0;
        while (!bus.m_tvalid && guard < 2000) begin
            @(negedge aclk);
            #2;
            guard++;
        end
        if (!bus.m_tvalid) fail_now("abc_m_tvalid_timeout");
        chk("out_state", 514'(dbg_state), 514'(ST_OUT));
        chk("out_s_tready", 514'(bus.s_tready), 514'(0));
        for (int h = 0; h < 10; h++) begin
            @(negedge aclk);
            #2;
            chk("abc_hold_valid", 514'(bus.m_tvalid), 514'(1));
            chk("abc_hold_data", 514'(bus.m_tdata), 514'(ABC_DIG));
        end
        chk("abc_cnt_before", 514'(msg_cnt), 514'(0));
        m_mode = 0;
        wait_done();
        chk("abc_msg_cnt", 514'(msg_cnt), 514'(1));
        chk("abc_nblk", 514'(blk_cnt - c0), 514'(1));
        chk("abc_byte3", 514'(last_blk[8*3 +: 8]), 514'(8'h80));
        chk("abc_byte63", 514'(last_blk[8*63 +: 8]), 514'(8'h18));

        // Stray digest strobe while idle.
        chk("err_before_stray", 514'(err), 514'(0));
        stray_cnt++;
        repeat (3) @(negedge aclk);
        #2;
        chk("err_after_stray", 514'(err), 514'(1));
        chk("stray_state", 514'(dbg_state), 514'(ST_DATA));
        repeat (5) @(negedge aclk);
        #2;
        chk("err_sticky", 514'(err), 514'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
